// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential shift-and-add multiplier.
package mult_pkg;

   localparam int MULT_WIDTH = 16;
   localparam int MULT_CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

endpackage : mult_pkg

// File: rtl/full_adder_16.sv
// 16-bit ripple-carry adder: one full-adder cell per bit, carry rippling LSB to MSB.
module full_adder_16 (
   input  logic [15:0] inp1,
   input  logic [15:0] inp2,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic carry;

   always_comb begin
      sum   = '0;
      carry = cin;
      for (int i = 0; i < 16; i++) begin
         sum[i] = inp1[i] ^ inp2[i] ^ carry;
         carry  = (inp1[i] & inp2[i]) | (carry & (inp1[i] ^ inp2[i]));
      end
      cout = carry;
   end

endmodule : full_adder_16

// File: rtl/seq_mult_16.sv
// Unsigned 16x16->32 shift-and-add multiplier, one multiplier bit per clock,
// built around the shared 16-bit ripple adder.
module seq_mult_16
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int CNT_W = MULT_CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   inp1,
   input  logic [WIDTH-1:0]   inp2,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   mult_state_t          state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic [WIDTH-1:0]     add_b;
   logic [WIDTH-1:0]     add_sum;
   logic                 add_cout;

   // Partial product is added only when the current multiplier LSB is set.
   assign add_b = acc_lo_q[0] ? mcand_q : '0;

   full_adder_16 u_adder (
      .inp1 (acc_hi_q),
      .inp2 (add_b),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      mcand_d   = mcand_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      product_d = product_q;
      ready     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            ready = 1'b1;
            done  = (state_q == DONE);
            if (state_q == DONE) begin
               state_d = IDLE;
            end
            if (start) begin
               mcand_d  = inp1;
               acc_lo_d = inp2;
               acc_hi_d = '0;
               count_d  = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            // 33-bit right shift of {cout, sum, acc_lo}; the carry lands in bit 31.
            acc_hi_d = {add_cout, add_sum[WIDTH-1:1]};
            acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
            count_d  = count_q + CNT_W'(1);
            if (count_q == CNT_W'(WIDTH - 1)) begin
               state_d   = DONE;
               product_d = {acc_hi_d, acc_lo_d};
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         count_q   <= '0;
         mcand_q   <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         mcand_q   <= mcand_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         product_q <= product_d;
      end
   end

   assign product = product_q;

endmodule : seq_mult_16

// File: tb/tb_seq_mult_16.sv
// Directed bench for seq_mult_16: latency, carry path, handshake and reset behaviour.
module tb_seq_mult_16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [15:0] inp1 = '0;
   logic [15:0] inp2 = '0;
   logic        ready;
   logic        busy;
   logic        done;
   logic [31:0] product;

   int checks = 0;
   int errors = 0;

   seq_mult_16 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .inp1    (inp1),
      .inp2    (inp2),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   // Present start for one rising edge; returns just after that edge (cycle 1 of the run).
   task automatic do_start(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      inp1  = a;
      inp2  = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts cycles from the accepting edge until done; gives up after 40 cycles.
   task automatic wait_done(output int lat, output int nbusy);
      lat   = 1;
      nbusy = busy ? 1 : 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (busy) nbusy++;
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if (product !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_outputs: product=%h busy=%b done=%b ready=%b, want 0/0/0/1",
                  product, busy, done, ready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: ready=%b busy=%b, want 1/0", ready, busy);
      end
   endtask

   task automatic test_basic();
      int lat, nbusy;
      do_start(16'h0003, 16'h0005);
      wait_done(lat, nbusy);
      checks++;
      if (lat !== 17) begin
         errors++;
         $display("FAIL basic_latency: got %0d cycles, want 17", lat);
      end
      checks++;
      if (nbusy !== 16) begin
         errors++;
         $display("FAIL basic_busy_cycles: got %0d, want 16", nbusy);
      end
      checks++;
      if (product !== 32'h0000000F) begin
         errors++;
         $display("FAIL basic_product: got %h, want 0000000f", product);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (product !== 32'h0000000F || done !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_hold: product=%h done=%b ready=%b, want 0000000f/0/1",
                  product, done, ready);
      end
   endtask

   task automatic test_carry();
      int lat, nbusy;
      do_start(16'hFFFF, 16'hFFFF);
      wait_done(lat, nbusy);
      checks++;
      if (product !== 32'hFFFE0001 || lat !== 17) begin
         errors++;
         $display("FAIL carry_product: got %h lat %0d, want fffe0001 lat 17", product, lat);
      end
   endtask

   task automatic test_zero_identity();
      int lat, nbusy;
      do_start(16'h0000, 16'hBEEF);
      wait_done(lat, nbusy);
      checks++;
      if (product !== 32'h00000000 || lat !== 17) begin
         errors++;
         $display("FAIL zero_product: got %h lat %0d, want 00000000 lat 17", product, lat);
      end
      do_start(16'h0001, 16'hBEEF);
      wait_done(lat, nbusy);
      checks++;
      if (product !== 32'h0000BEEF || lat !== 17) begin
         errors++;
         $display("FAIL identity_product: got %h lat %0d, want 0000beef lat 17", product, lat);
      end
   endtask

   task automatic test_ignored_start();
      int ndone = 0;
      int done_at = -1;
      do_start(16'h1234, 16'h0010);
      for (int c = 1; c <= 22; c++) begin
         if (done) begin
            ndone++;
            if (done_at < 0) done_at = c;
            checks++;
            if (product !== 32'h00012340) begin
               errors++;
               $display("FAIL ignored_start_product: got %h, want 00012340", product);
            end
         end
         if (c == 5) begin
            inp1  = 16'hFFFF;
            inp2  = 16'hFFFF;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      checks++;
      if (ndone !== 1 || done_at !== 17) begin
         errors++;
         $display("FAIL ignored_start_done: %0d pulses first at %0d, want 1 at 17", ndone, done_at);
      end
   endtask

   task automatic test_back_to_back();
      int lat, nbusy;
      int bad_hold = 0;
      do_start(16'h0002, 16'h0003);
      wait_done(lat, nbusy);
      checks++;
      if (product !== 32'h00000006 || done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: product=%h done=%b, want 00000006/1", product, done);
      end
      inp1  = 16'h0100;
      inp2  = 16'h0100;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_idle: busy=%b ready=%b, want 1/0", busy, ready);
      end
      lat = 1;
      while (!done && lat < 40) begin
         if (product !== 32'h00000006) bad_hold++;
         @(negedge clk);
         lat++;
      end
      checks++;
      if (bad_hold !== 0) begin
         errors++;
         $display("FAIL b2b_hold: product changed in %0d cycles, want 0", bad_hold);
      end
      checks++;
      if (product !== 32'h00010000 || lat !== 17) begin
         errors++;
         $display("FAIL b2b_second: got %h lat %0d, want 00010000 lat 17", product, lat);
      end
   endtask

   task automatic test_reset_mid_run();
      int lat, nbusy;
      do_start(16'hABCD, 16'h1234);
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (product !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_run: product=%h busy=%b done=%b ready=%b, want 0/0/0/1",
                  product, busy, done, ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_start(16'h0007, 16'h0009);
      wait_done(lat, nbusy);
      checks++;
      if (product !== 32'h0000003F || lat !== 17) begin
         errors++;
         $display("FAIL reset_recover: got %h lat %0d, want 0000003f lat 17", product, lat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_zero_identity();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_seq_mult_16

// File: doc/seq_mult_16.md
Name: seq_mult_16

Overview:
- Multi-cycle unsigned 16x16 -> 32-bit shift-and-add multiplier. It sits directly around the existing 16-bit ripple adder (full_adder_16): it feeds that adder its operands each cycle and consumes its sum and carry-out.
- Used by the CPU execute stage for MUL instructions.
- Processes one multiplier bit per clock under a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand width. Only 16 is supported because the adder instance is fixed at 16 bits.
- CNT_W, 5, iteration counter width. Must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a multiply. Sampled only when ready=1.
- inp1  input  16  multiplicand, latched on an accepted start.
- inp2  input  16  multiplier, latched on an accepted start.
- ready  output  1  block can accept start (state IDLE or DONE).
- busy  output  1  multiply in progress (state RUN).
- done  output  1  one-cycle pulse: product is valid.
- product  output  32  result. Held stable until the next accepted start.

Behaviour:
- Reset is asynchronous, active-low, single clock domain. While rst_n=0:
  - state=IDLE, count=0, mcand_q=0, acc_hi=0, acc_lo=0.
  - product=0, done=0, busy=0, ready=1.
- States and transitions:
  - IDLE -> RUN on start=1.
  - RUN -> DONE when count reaches 15 and that iteration completes.
  - DONE -> RUN on start=1; otherwise DONE -> IDLE.
- Accepted start (IDLE or DONE):
  - mcand_q<=inp1, acc_lo<=inp2, acc_hi<=0, count<=0, state<=RUN.
  - product keeps its previous value until the new run ends.
- RUN iteration (one per clock):
  - full_adder_16 is driven with inp1=acc_hi, inp2=(acc_lo[0] ? mcand_q : 16'h0000), cin=0.
  - Register update: {acc_hi, acc_lo} <= {cout, sum, acc_lo[15:1]}. This is a 33-bit right shift; the adder carry enters bit 31.
  - count<=count+1.
- End of run:
  - On the edge where count==15 in RUN, state<=DONE and product<={next acc_hi, next acc_lo}.
- DONE state: done=1 for exactly one cycle.
- Latency: start sampled at edge N -> RUN for edges N+1..N+16 -> done=1 and product valid in the cycle after edge N+16. That is 17 cycles from start to done.
- Back-to-back: start=1 during the DONE cycle is accepted. The next run begins with no IDLE gap, and done still pulses for that cycle.
- start=1 while busy is ignored. Operands and progress are unaffected, and there is no error flag.
- inp1/inp2 changes after acceptance have no effect.
- Operand 0 on either side gives product=0 after the full 16 iterations. There is no early exit, so latency is constant.
- Arithmetic is unsigned only. The 32-bit product cannot overflow; the adder cout is never discarded.
- Reset mid-RUN aborts immediately: all outputs return to their reset values and the partial result is lost.
- Outputs ready, busy and done are decoded from state only, never from inputs (Moore).

Decomposition:
- Shared package mult_pkg holds:
  - constants MULT_WIDTH=16 and MULT_CNT_W=5;
  - state enum mult_state_t {IDLE, RUN, DONE}, 2-bit encoding.
- Sub-module: one instance of the existing full_adder_16 as the datapath adder. No new sub-module. The FSM, counter and shift register stay in seq_mult_16.

Test Plan:
- Basic: inp1=0x0003, inp2=0x0005, start one cycle from IDLE -> busy=1 for 16 cycles; done pulses at cycle 17; product=0x0000000F, held after done.
- Carry path: inp1=0xFFFF, inp2=0xFFFF -> product=0xFFFE0001. This checks that adder cout is shifted into bit 31 every iteration.
- Zero/identity: 0x0000 x 0xBEEF -> 0x00000000 with 17-cycle latency; 0x0001 x 0xBEEF -> 0x0000BEEF.
- Ignored start: start 0x1234 x 0x0010, then pulse start with 0xFFFF x 0xFFFF at RUN cycle 5 -> product=0x00012340; done fires once at cycle 17.
- Back-to-back: during the done cycle of 0x0002 x 0x0003 (product 0x00000006), assert start with 0x0100 x 0x0100 -> no IDLE cycle; busy next cycle; second product=0x00010000 at 17 cycles; product stays 0x00000006 throughout the second run.
- Reset mid-run: assert rst_n=0 asynchronously at RUN cycle 8 -> product=0, busy=0, done=0, ready=1 immediately. After release, a fresh 0x0007 x 0x0009 run gives 0x0000003F.
